signed_add_arbiter: RTL

Shares one external 32-bit signed two's-complement adder between NUM_REQ requesters using round-robin arbitration. Each requester presents an operand pair with a valid/ready handshake. The block drives the winning operands into the shared adder, registers the sum and an overflow flag, and returns them with the requester ID on a single valid/ready response channel. It sits between the client blocks and the combinational adder datapath.

---
 rtl/signed_add_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/signed_add_arbiter.sv
// Round-robin front end that time-shares one external combinational signed
// adder between NUM_REQ requesters and returns each sum on one response channel.
module signed_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_ovf,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [WIDTH-1:0]   r_rsp_sum;
  logic               r_rsp_ovf;

  logic               w_grant_any;
  logic [ID_W-1:0]    w_grant_id;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_ovf;
  logic [ID_W-1:0]    w_rr_next;

  // First valid requester at or after r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : grant_scan
    int idx;
    // NOTE: every variable gets a default before any conditional write so the
    // block stays purely combinational (no inferred latch).
    idx         = 0;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_grant_any && req_valid[idx]) begin
        w_grant_any = 1'b1;
        w_grant_id  = ID_W'(idx);
      end
    end
  end

  assign w_grant_oh = NUM_REQ'(1) << w_grant_id;
  assign w_sel_a    = req_a[int'(w_grant_id)*WIDTH +: WIDTH];
  assign w_sel_b    = req_b[int'(w_grant_id)*WIDTH +: WIDTH];

  // Overflow only when both operands share a sign the result does not.
  assign w_ovf = (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                 (add_sum[WIDTH-1] != r_op_a[WIDTH-1]);

  assign w_rr_next = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);

  // Gated by rst_n so an asserted reset forces every ready low at once.
  assign req_ready = (rst_n && (r_state == S_IDLE) && w_grant_any) ? w_grant_oh : '0;

  assign add_a     = r_op_a;
  assign add_b     = r_op_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_ovf   = r_rsp_ovf;
  assign busy      = (r_state != S_IDLE);

  // NOTE: non-blocking assignments throughout so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_id    <= w_grant_id;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rsp_sum   <= add_sum;
          r_rsp_ovf   <= w_ovf;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= w_rr_next;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
